// File: rtl/grf_sb_pkg.sv
// grf_sb_pkg: shared defaults, register-0 constant, packed-port slice helper
// and the signed busy-count delta type used by the register file.
package grf_sb_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int ZERO_REG   = 0;
    localparam int PACK_MAX   = 256;
    localparam int SLICE_MAX  = 64;

    typedef logic signed [1:0] cnt_delta_t;

    localparam cnt_delta_t DELTA_DEC  = -2'sd1;
    localparam cnt_delta_t DELTA_NONE = 2'sd0;
    localparam cnt_delta_t DELTA_INC  = 2'sd1;

    // Extract field k of width w from a packed multi-port vector.
    function automatic logic [SLICE_MAX-1:0] port_slice(
        input logic [PACK_MAX-1:0] vec,
        input int unsigned         k,
        input int unsigned         w
    );
        port_slice = SLICE_MAX'(vec >> (k * w));
    endfunction

endpackage

// File: rtl/grf_sb_scoreboard.sv
// grf_sb_scoreboard: per-register busy bits with flush and a registered
// popcount (busy_cnt) maintained incrementally from set/clear events.
module grf_sb_scoreboard
    import grf_sb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    set_en,
    input  logic [ADDR_W-1:0]       set_addr,
    input  logic                    clr_en,
    input  logic [ADDR_W-1:0]       clr_addr,
    input  logic                    flush,
    output logic [(2**ADDR_W)-1:0]  busy,
    output logic [ADDR_W:0]         busy_cnt
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0]       busy_r;
    logic [DEPTH-1:0]       busy_nxt_s;
    logic [DEPTH-1:0]       set_mask_s;
    logic [DEPTH-1:0]       clr_mask_s;
    logic [ADDR_W:0]        cnt_r;
    logic [ADDR_W:0]        cnt_nxt_s;
    logic                   inc_s;
    logic                   dec_s;
    cnt_delta_t             delta_s;
    logic signed [ADDR_W:0] delta_ext_s;

    // The set mask is applied after the clear mask so a same-edge issue wins.
    assign set_mask_s = DEPTH'(set_en) << set_addr;
    assign clr_mask_s = DEPTH'(clr_en) << clr_addr;
    assign busy_nxt_s = flush ? {DEPTH{1'b0}} : ((busy_r & ~clr_mask_s) | set_mask_s);

    assign inc_s = set_en & ~busy_r[set_addr];
    assign dec_s = clr_en & busy_r[clr_addr] & ~(set_en & (set_addr == clr_addr));

    // Collapse the set/clear events into a single signed count step.
    always_comb begin
        delta_s = DELTA_NONE;
        case ({inc_s, dec_s})
            2'b10:   delta_s = DELTA_INC;
            2'b01:   delta_s = DELTA_DEC;
            default: delta_s = DELTA_NONE;
        endcase
    end

    assign delta_ext_s = delta_s;
    assign cnt_nxt_s   = flush ? {(ADDR_W+1){1'b0}} : (cnt_r + $unsigned(delta_ext_s));

    // Busy vector and its popcount state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r <= {DEPTH{1'b0}};
            cnt_r  <= {(ADDR_W+1){1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
            cnt_r  <= cnt_nxt_s;
        end
    end

    assign busy     = busy_r;
    assign busy_cnt = cnt_r;

endmodule

// File: rtl/grf_sb.sv
// grf_sb: parametrised register file with write-through bypass and a busy
// scoreboard. Define GRF_TRACE_EN to print a commit line for every write.
module grf_sb
    import grf_sb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          wa,
    input  logic [DATA_W-1:0]          wd,
    input  logic [31:0]                w_pc,
    input  logic                       iss_en,
    input  logic [ADDR_W-1:0]          iss_addr,
    input  logic                       flush,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_ready,
    output logic [ADDR_W:0]            busy_cnt
);

    localparam int                DEPTH     = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regs_r [DEPTH];
    logic [DEPTH-1:0]  busy_s;
    logic              wr_ok_s;
    logic              iss_ok_s;

    // Gating with reset keeps the bypass from leaking wd while in reset.
    assign wr_ok_s  = reset & we & (wa != ZERO_ADDR);
    assign iss_ok_s = iss_en & (iss_addr != ZERO_ADDR) & ~flush;

    grf_sb_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .set_en   (iss_ok_s),
        .set_addr (iss_addr),
        .clr_en   (wr_ok_s),
        .clr_addr (wa),
        .flush    (flush),
        .busy     (busy_s),
        .busy_cnt (busy_cnt)
    );

    // Register storage; entry 0 is never written and so always reads zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_ok_s) begin
            regs_r[wa] <= wd;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr_s;
        logic              bypass_s;

        assign addr_s   = ADDR_W'(port_slice(PACK_MAX'(rd_addr), k, ADDR_W));
        assign bypass_s = wr_ok_s & (addr_s == wa);

        assign rd_data[k*DATA_W +: DATA_W] = bypass_s ? wd : regs_r[addr_s];
        assign rd_ready[k]                 = bypass_s | ~busy_s[addr_s];
    end

`ifdef GRF_TRACE_EN
    // Commit trace: one line per accepted write.
    always @(posedge clk) begin
        if (wr_ok_s) begin
            $display("%0t@%h: $%0d <= %h", $time, w_pc, wa, wd);
        end
    end
`else
    logic unused_pc_s;
    assign unused_pc_s = ^w_pc;
`endif

endmodule

// File: doc/grf_sb.md
Name: grf_sb

Overview:
- Parametrised successor of the single-write, two-read general register file.
- Configurable width, depth and read-port count, with internal write-through bypass.
- Adds a per-register busy scoreboard: set when a producer issues, cleared when that producer writes back. Decode uses it for stall decisions.
- Sits between decode (reads, issue) and write-back (write port) of the pipelined CPU.

Parameters:
DATA_W, 32, data width of each register
ADDR_W, 5, register address width; depth = 2**ADDR_W
NUM_RD, 2, number of independent combinational read ports (1..4)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
we  in  1  write-back enable
wa  in  ADDR_W  write address
wd  in  DATA_W  write data
w_pc  in  32  PC of the writing instruction (trace only)
iss_en  in  1  issue enable: the destination wa_iss becomes busy
iss_addr  in  ADDR_W  destination register of the issuing instruction
flush  in  1  synchronous clear of all busy bits
rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k at [k*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed read data
rd_ready  out  NUM_RD  1 = read value is architecturally valid
busy_cnt  out  ADDR_W+1  number of registers currently busy

Behaviour:
- Reset (reset=0, asynchronous): all registers = 0, all busy bits = 0, busy_cnt = 0. During reset rd_data = 0 and rd_ready = all ones.
- Register 0:
  - Always reads 0 and is always ready.
  - Writes to it are discarded.
  - Issue to it is ignored and does not change busy_cnt.
- Write: on a rising clk with we=1 and wa!=0, regs[wa] <= wd and busy[wa] is cleared.
- Read (combinational, zero latency), per port k:
  - If we=1, wa!=0 and rd_addr_k==wa, then rd_data_k = wd (bypass) and rd_ready_k = 1.
  - Else rd_data_k = regs[rd_addr_k] and rd_ready_k = !busy[rd_addr_k].
  - All ports are independent; identical addresses on several ports are legal.
- Issue: on a rising clk with iss_en=1, iss_addr!=0 and flush=0, busy[iss_addr] <= 1.
- Same-cycle write and issue to the same nonzero register: data is written and the busy bit ends set (issue wins, since the new producer is younger). Bypass still reports ready this cycle.
- Re-issue to an already-busy register: busy stays 1 and busy_cnt is unchanged; there is no per-register nesting count.
- Flush: on a rising clk with flush=1, all busy bits <= 0 and any same-cycle issue is ignored. A same-cycle write still updates data.
- busy_cnt:
  - Registered; always equals the popcount of the busy bits after each edge.
  - Next value = current + (issue sets a previously clear bit) - (write clears a previously set bit, without issue to the same register).
  - A simultaneous set and clear on different registers leaves it unchanged.
  - After flush it is 0.
  - Never exceeds 2**ADDR_W-1.
- Write to a non-busy register is legal: data updates and busy stays 0.

Optional Feature:
- GRF_TRACE_EN defined: every accepted write (we=1, wa!=0, reset high) prints "<time>@<w_pc hex>: $<wa decimal> <= <wd hex>" at the clock edge. Register-0 writes print nothing.
- Undefined: no simulation output and no trace logic; w_pc is unused.

Decomposition:
- Shared package holds:
  - DATA_W/ADDR_W defaults
  - ZERO_REG constant (0)
  - a function packing/unpacking port k slices
  - the popcount delta type (signed 2-bit: -1, 0, +1)
- One natural sub-module, grf_sb_scoreboard: busy bits, flush and busy_cnt. Its inputs are the decoded issue, write and flush; its output is the busy vector.
- The top keeps the storage array and NUM_RD generate-loop read muxes with bypass.

Test Plan:
- Reset release, read ports 0/1 at addr 3 and 31 -> rd_data=0, rd_ready=2'b11, busy_cnt=0.
- Issue addr 5; next cycle read 5 -> rd_ready_k=0, busy_cnt=1. Then we=1, wa=5, wd=32'hDEADBEEF, read 5 in the same cycle -> rd_data=DEADBEEF (bypass), ready=1. Next cycle: busy_cnt=0, read from array = DEADBEEF.
- Same edge: we=1, wa=7, wd=32'h11 and iss_en=1, iss_addr=7 (7 previously busy) -> regs[7]=0x11, busy[7]=1, busy_cnt unchanged.
- Issue 1, 2, 3 over successive cycles (busy_cnt=3), then flush=1 with iss_en=1, iss_addr=4 -> busy_cnt=0, all read ports ready.
- we=1, wa=0, wd=32'hFFFFFFFF and iss_en=1, iss_addr=0 -> reads of 0 return 0, ready=1, busy_cnt unchanged; with GRF_TRACE_EN, no print.
- Drive reset low asynchronously mid-cycle with busy_cnt=4 and regs nonzero -> outputs go to reset values immediately, without waiting for clk.
